// File: rtl/vga_pattern_gen_if.sv
// AXI4-Stream video pixel channel carried between the pattern generator and its sink.
//   pix_tvalid : beat valid (source)
//   pix_tready : sink ready (sink)
//   pix_tdata  : RGB pixel, [2]=R, [1]=G, [0]=B (source)
//   pix_tlast  : last pixel of a line (source)
//   pix_tuser  : start of frame, pixel (0,0) (source)
interface vga_pattern_gen_if;
   logic            pix_tvalid;
   logic            pix_tready;
   logic [2:0][7:0] pix_tdata;
   logic            pix_tlast;
   logic            pix_tuser;

   modport master (
      output pix_tvalid,
      output pix_tdata,
      output pix_tlast,
      output pix_tuser,
      input  pix_tready
   );

   modport slave (
      input  pix_tvalid,
      input  pix_tdata,
      input  pix_tlast,
      input  pix_tuser,
      output pix_tready
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern video source streaming frames over AXI4-Stream.
//   aclk, aresetn : clock, asynchronous active-low reset
//   enable        : run request, sampled in IDLE and at frame end
//   pattern_sel   : 0 colour bars, 1 horizontal ramp, 2 checkerboard, 3 solid
//   h_res, v_res  : active pixels per line / lines per frame
//   solid_color   : RGB used by the solid pattern
//   pix           : AXI4-Stream pixel channel (master side)
//   frame_cnt     : completed frames, wrapping
// The output registers always hold the pixel at (x, y); on each accepted beat
// they are reloaded with the following pixel, giving one pixel per clock.
module vga_pattern_gen #(
   parameter int unsigned DEFAULT_PATTERN = 0
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic [1:0]           pattern_sel,
   input  logic [15:0]          h_res,
   input  logic [15:0]          v_res,
   input  logic [2:0][7:0]      solid_color,
   vga_pattern_gen_if.master    pix,
   output logic [15:0]          frame_cnt
);

   localparam int unsigned CW = 16;
   localparam int unsigned PW = 2;
   localparam int unsigned BW = 3;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t           state, state_nxt;

   logic [CW-1:0]    h_lat, v_lat;
   logic [PW-1:0]    pat_lat;
   logic [2:0][7:0]  solid_lat;
   logic [CW-1:0]    x, y, bar_cnt;
   logic [BW-1:0]    bar_idx;

   logic             xfer, cfg_ok, x_last, y_last;
   logic             start, advance, frame_inc, tvalid_nxt;

   logic [PW-1:0]    pat_eff;
   logic [CW-1:0]    h_eff, bw;
   logic [2:0][7:0]  solid_eff;
   logic [CW-1:0]    x_nxt, y_nxt, cnt_nxt;
   logic [BW-1:0]    idx_nxt;
   logic [2:0][7:0]  color_nxt;
   logic             tlast_nxt, tuser_nxt;

   // Out-of-range selections fall back to the default pattern.
   function automatic logic [PW-1:0] sel_map(input logic [PW-1:0] sel);
      logic [PW-1:0] r;
      case (sel)
         2'd0, 2'd1, 2'd2, 2'd3: r = sel;
         default:                r = PW'(DEFAULT_PATTERN);
      endcase
      return r;
   endfunction

   // Colour-bar palette, white through black.
   function automatic logic [23:0] bar_rgb(input logic [BW-1:0] idx);
      logic [23:0] r;
      case (idx)
         3'd0:    r = 24'hFFFFFF;
         3'd1:    r = 24'hFFFF00;
         3'd2:    r = 24'h00FFFF;
         3'd3:    r = 24'h00FF00;
         3'd4:    r = 24'hFF00FF;
         3'd5:    r = 24'hFF0000;
         3'd6:    r = 24'h0000FF;
         default: r = 24'h000000;
      endcase
      return r;
   endfunction

   assign xfer   = pix.pix_tvalid & pix.pix_tready;
   assign cfg_ok = enable && (h_res != '0) && (v_res != '0);
   assign x_last = (x == h_lat - CW'(1));
   assign y_last = (y == v_lat - CW'(1));

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and beat control
   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      advance    = 1'b0;
      frame_inc  = 1'b0;
      tvalid_nxt = pix.pix_tvalid;
      case (state)
         IDLE: begin
            tvalid_nxt = 1'b0;
            if (cfg_ok) begin
               state_nxt  = ACTIVE;
               start      = 1'b1;
               tvalid_nxt = 1'b1;
            end
         end
         ACTIVE: begin
            if (xfer) begin
               if (x_last && y_last) begin
                  frame_inc = 1'b1;
                  if (cfg_ok) begin
                     start = 1'b1;
                  end else begin
                     state_nxt  = IDLE;
                     tvalid_nxt = 1'b0;
                  end
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: begin
            state_nxt  = IDLE;
            tvalid_nxt = 1'b0;
         end
      endcase
   end

   // Next pixel coordinates and colour; a frame start uses the live config.
   always_comb begin
      pat_eff   = start ? sel_map(pattern_sel) : pat_lat;
      h_eff     = start ? h_res : h_lat;
      solid_eff = start ? solid_color : solid_lat;
      bw        = h_eff >> 3;
      x_nxt     = x;
      y_nxt     = y;
      idx_nxt   = bar_idx;
      cnt_nxt   = bar_cnt;
      if (start) begin
         x_nxt   = '0;
         y_nxt   = '0;
         idx_nxt = '0;
         cnt_nxt = '0;
      end else if (advance) begin
         if (x_last) begin
            x_nxt   = '0;
            y_nxt   = y + CW'(1);
            idx_nxt = '0;
            cnt_nxt = '0;
         end else begin
            x_nxt = x + CW'(1);
            // Bar index saturates at 7 so remainder pixels stay in the last bar.
            if ((bw != '0) && (bar_idx != 3'd7)) begin
               if (bar_cnt == bw - CW'(1)) begin
                  idx_nxt = bar_idx + BW'(1);
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = bar_cnt + CW'(1);
               end
            end
         end
      end

      case (pat_eff)
         2'd0:    color_nxt = bar_rgb(idx_nxt);
         2'd1:    color_nxt = {x_nxt[7:0], x_nxt[7:0], x_nxt[7:0]};
         2'd2:    color_nxt = (x_nxt[5] ^ y_nxt[5]) ? 24'hFFFFFF : 24'h000000;
         default: color_nxt = solid_eff;
      endcase

      tlast_nxt = (x_nxt == h_eff - CW'(1));
      tuser_nxt = (x_nxt == '0) && (y_nxt == '0);
   end

   // Datapath and output registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pix.pix_tvalid <= 1'b0;
         pix.pix_tdata  <= '0;
         pix.pix_tlast  <= 1'b0;
         pix.pix_tuser  <= 1'b0;
         frame_cnt      <= '0;
         x              <= '0;
         y              <= '0;
         bar_idx        <= '0;
         bar_cnt        <= '0;
         h_lat          <= '0;
         v_lat          <= '0;
         pat_lat        <= '0;
         solid_lat      <= '0;
      end else begin
         pix.pix_tvalid <= tvalid_nxt;
         if (start || advance) begin
            x             <= x_nxt;
            y             <= y_nxt;
            bar_idx       <= idx_nxt;
            bar_cnt       <= cnt_nxt;
            pix.pix_tdata <= color_nxt;
            pix.pix_tlast <= tlast_nxt;
            pix.pix_tuser <= tuser_nxt;
         end
         if (start) begin
            h_lat     <= h_res;
            v_lat     <= v_res;
            pat_lat   <= sel_map(pattern_sel);
            solid_lat <= solid_color;
         end
         if (frame_inc) frame_cnt <= frame_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: random backpressure and configs
// checked beat by beat against a frame-level reference model.
module tb_vga_pattern_gen;

   localparam int LIMIT = 20000;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic            enable;
   logic [1:0]      pattern_sel;
   logic [15:0]     h_res, v_res;
   logic [2:0][7:0] solid_color;
   logic [15:0]     frame_cnt;

   vga_pattern_gen_if pix();

   vga_pattern_gen #(.DEFAULT_PATTERN(0)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .h_res       (h_res),
      .v_res       (v_res),
      .solid_color (solid_color),
      .pix         (pix.master),
      .frame_cnt   (frame_cnt)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          m_active, m_pat, m_h, m_v, m_x, m_y, m_starts, m_beats;
   logic [23:0] m_solid;
   logic [15:0] m_frames;
   int          ready_pct;

   // Outputs seen at the previous sample, for stall-hold checks
   logic        p_valid, p_last, p_user;
   logic [23:0] p_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] exp_color(input int p, input int h, input int x, input int y,
                                             input logic [23:0] s);
      int bw, bar;
      logic [7:0] xb;
      case (p)
         0: begin
            bw  = h / 8;
            bar = (bw == 0) ? 0 : x / bw;
            if (bar > 7) bar = 7;
            case (bar)
               0: return 24'hFFFFFF;
               1: return 24'hFFFF00;
               2: return 24'h00FFFF;
               3: return 24'h00FF00;
               4: return 24'hFF00FF;
               5: return 24'hFF0000;
               6: return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         1: begin
            xb = 8'(x % 256);
            return {xb, xb, xb};
         end
         2: return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
         default: return s;
      endcase
   endfunction

   // One clock: choose tready, advance the model by the spec rules, then check.
   task automatic step();
      logic        rdy;
      logic [23:0] got;
      int          ok;
      rdy = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      pix.pix_tready = rdy;
      ok = (enable && h_res != 0 && v_res != 0) ? 1 : 0;
      if (m_active == 0) begin
         if (ok != 0) begin
            m_active = 1; m_pat = int'(pattern_sel); m_h = int'(h_res); m_v = int'(v_res);
            m_solid = solid_color; m_x = 0; m_y = 0; m_starts++;
         end
      end else if (rdy) begin
         m_beats++;
         if (m_x == m_h - 1 && m_y == m_v - 1) begin
            m_frames = m_frames + 16'd1;
            if (ok != 0) begin
               m_pat = int'(pattern_sel); m_h = int'(h_res); m_v = int'(v_res);
               m_solid = solid_color; m_x = 0; m_y = 0; m_starts++;
            end else begin
               m_active = 0;
            end
         end else if (m_x == m_h - 1) begin
            m_x = 0; m_y++;
         end else begin
            m_x++;
         end
      end
      @(posedge aclk);
      #1;
      got = pix.pix_tdata;
      if (p_valid && !rdy) begin
         check_eq("hold_valid", 32'(pix.pix_tvalid), 32'd1);
         check_eq("hold_data", 32'(got), 32'(p_data));
         check_eq("hold_last", 32'(pix.pix_tlast), 32'(p_last));
         check_eq("hold_user", 32'(pix.pix_tuser), 32'(p_user));
      end
      check_eq("tvalid", 32'(pix.pix_tvalid), 32'(m_active));
      check_eq("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      if (m_active != 0) begin
         check_eq("tdata", 32'(got), 32'(exp_color(m_pat, m_h, m_x, m_y, m_solid)));
         check_eq("tlast", 32'(pix.pix_tlast), 32'(m_x == m_h - 1));
         check_eq("tuser", 32'(pix.pix_tuser), 32'(m_x == 0 && m_y == 0));
      end
      p_valid = pix.pix_tvalid; p_data = got; p_last = pix.pix_tlast; p_user = pix.pix_tuser;
   endtask

   // Stream nframes frames; enable drops once they have all started and
   // drop_beat beats have passed; pattern_sel switches at chg_beat if >= 0.
   task automatic run_frames(input int pat, input int h, input int v, input logic [23:0] solid,
                             input int pct, input int nframes, input int drop_beat,
                             input int chg_beat, input int chg_pat);
      int f0, b0, s0, n;
      pattern_sel = 2'(pat); h_res = 16'(h); v_res = 16'(v); solid_color = solid;
      ready_pct = pct; f0 = int'(m_frames); b0 = m_beats; s0 = m_starts; enable = 1'b1; n = 0;
      do begin
         if (m_starts - s0 >= nframes && m_beats - b0 >= drop_beat) enable = 1'b0;
         if (chg_beat >= 0 && m_beats - b0 == chg_beat) pattern_sel = 2'(chg_pat);
         step();
         n++;
      end while (m_active != 0 && n < LIMIT);
      check_eq("run_done", 32'(m_active), 32'd0);
      check_eq("idle_after", 32'(pix.pix_tvalid), 32'd0);
      check_eq("frames_done", 32'(frame_cnt), 32'((f0 + nframes) % 65536));
      check_eq("beat_total", 32'(m_beats - b0), 32'(nframes * h * v));
      enable = 1'b0;
      step();
   endtask

   initial begin
      int b0, n;
      aresetn = 1'b0; enable = 1'b0; pattern_sel = '0; h_res = '0; v_res = '0;
      solid_color = '0; pix.pix_tready = 1'b0; ready_pct = 100;
      m_active = 0; m_pat = 0; m_h = 0; m_v = 0; m_x = 0; m_y = 0; m_starts = 0; m_beats = 0;
      m_solid = '0; m_frames = '0;
      p_valid = 1'b0; p_data = '0; p_last = 1'b0; p_user = 1'b0;

      repeat (3) @(posedge aclk);
      #2;
      check_eq("rst_tvalid", 32'(pix.pix_tvalid), 32'd0);
      check_eq("rst_tdata", 32'(pix.pix_tdata), 32'd0);
      check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      aresetn = 1'b1;

      // Colour bars, two pixels per bar
      run_frames(0, 16, 2, 24'h0, 100, 1, 0, -1, 0);
      // Remainder pixels stay black; narrow line stays white
      run_frames(0, 19, 2, 24'h0, 100, 1, 0, -1, 0);
      run_frames(0, 5, 1, 24'h0, 100, 1, 0, -1, 0);
      // Ramp under random backpressure
      run_frames(1, 300, 2, 24'h0, 50, 1, 0, -1, 0);
      // Mid-frame switch from solid to checker takes effect next frame
      run_frames(3, 64, 40, 24'h3C5A96, 100, 2, 0, 100, 2);
      // Enable dropped in line 1 of 4: frame completes
      run_frames(2, 8, 4, 24'h0, 70, 1, 10, -1, 0);

      // Zero width never starts
      ready_pct = 100; h_res = 16'd0; v_res = 16'd4; enable = 1'b1;
      repeat (8) step();
      check_eq("zero_idle", 32'(pix.pix_tvalid), 32'd0);
      enable = 1'b0;
      step();

      // Random configurations
      for (int i = 0; i < 6; i++) begin
         run_frames(int'($urandom_range(0, 3)), int'($urandom_range(1, 70)),
                    int'($urandom_range(1, 3)), 24'($urandom), int'($urandom_range(30, 100)),
                    int'($urandom_range(1, 2)), 0, -1, 0);
      end

      // Asynchronous reset mid-line
      pattern_sel = 2'd1; h_res = 16'd40; v_res = 16'd3; ready_pct = 100; enable = 1'b1;
      b0 = m_beats; n = 0;
      while (m_beats - b0 < 15 && n < LIMIT) begin
         step();
         enable = 1'b0;
         n++;
      end
      check_eq("pre_rst_active", 32'(pix.pix_tvalid), 32'd1);
      #2 aresetn = 1'b0;
      #1;
      check_eq("arst_tvalid", 32'(pix.pix_tvalid), 32'd0);
      check_eq("arst_tdata", 32'(pix.pix_tdata), 32'd0);
      check_eq("arst_tlast", 32'(pix.pix_tlast), 32'd0);
      check_eq("arst_tuser", 32'(pix.pix_tuser), 32'd0);
      check_eq("arst_frame_cnt", 32'(frame_cnt), 32'd0);
      m_active = 0; m_frames = '0; p_valid = 1'b0;
      #3 aresetn = 1'b1;
      run_frames(1, 40, 3, 24'h0, 60, 1, 0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The module SHALL have parameter DEFAULT_PATTERN, default 0, pattern used when pattern_sel is out of range (0..3).
REQ-002 The module SHALL have port aclk  input  1  single clock for all logic.
REQ-003 The module SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port enable  input  1  run request; sampled only in IDLE and at frame end.
REQ-005 The module SHALL have port pattern_sel  input  2  0 colour bars, 1 horizontal ramp, 2 checkerboard, 3 solid.
REQ-006 The module SHALL have port h_res  input  16  active pixels per line.
REQ-007 The module SHALL have port v_res  input  16  active lines per frame.
REQ-008 The module SHALL have port solid_color  input  [2:0][7:0]  RGB for pattern 3.
REQ-009 The module SHALL have port pix_tvalid  output  1  AXI4-Stream video valid.
REQ-010 The module SHALL have port pix_tready  input  1  downstream ready.
REQ-011 The module SHALL have port pix_tdata  output  [2:0][7:0]  pixel: [2]=R, [1]=G, [0]=B.
REQ-012 The module SHALL have port pix_tlast  output  1  end of line, last pixel of each line.
REQ-013 The module SHALL have port pix_tuser  output  1  start of frame, pixel (0,0) only.
REQ-014 The module SHALL have port frame_cnt  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-015 The FSM SHALL have two states: IDLE (tvalid=0) and ACTIVE (streaming a frame).
REQ-016 IDLE->ACTIVE SHALL occur when enable=1 and h_res!=0 and v_res!=0; pixel (0,0) is presented with tvalid=1 on the next cycle.
REQ-017 On IDLE->ACTIVE, pattern_sel, h_res, v_res and solid_color SHALL be latched; changes mid-frame take effect only at the next frame start.
REQ-018 A beat SHALL transfer only when tvalid=1 and tready=1; while tvalid=1 and tready=0, tdata, tlast and tuser SHALL hold stable.
REQ-019 Once asserted, tvalid SHALL NOT deassert until the transfer completes; tvalid SHALL NOT depend combinationally on tready.
REQ-020 The x counter SHALL increment per transfer and wrap to 0 after x=h_res-1; the y counter SHALL increment on that wrap.
REQ-021 pix_tlast SHALL be 1 iff x=h_res-1; pix_tuser SHALL be 1 iff x=0 and y=0.
REQ-022 Sustained throughput SHALL be one pixel per clock while tready=1, with no bubble at line or frame boundaries.
REQ-023 On transfer of pixel (h_res-1, v_res-1), frame_cnt SHALL increment.
REQ-024 In the same cycle, if enable=1, the FSM SHALL start the next frame back-to-back with fresh latched config; otherwise it SHALL go to IDLE.
REQ-025 Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-026 Pattern 0 SHALL use bar width bw=h_res>>3 and a bar index advancing every bw pixels, saturating at 7, so remainder pixels stay in bar 7.
REQ-027 If bw=0, pattern 0 SHALL output bar 0 for the whole line.
REQ-028 Bar colours 0..7 SHALL be FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; no divider is permitted.
REQ-029 Pattern 1 SHALL output R=G=B=x[7:0].
REQ-030 Pattern 2 SHALL output FFFFFF when x[5]^y[5]=1, else 000000.
REQ-031 Pattern 3 SHALL output the latched solid_color.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On aresetn=0, regardless of state, the FSM SHALL go to IDLE and pix_tvalid, pix_tlast, pix_tuser, pix_tdata, frame_cnt, x, y and the bar counter SHALL clear to 0.
REQ-034 Reset mid-frame SHALL abandon the frame; after release, the next frame SHALL start at (0,0) with tuser=1.

Verification
REQ-035 Bars: h_res=16, v_res=2, pattern 0, tready=1 -> 32 beats, each colour twice per line, tlast at beats 15 and 31, tuser at beat 0 only, frame_cnt 0->1.
REQ-036 Remainder: h_res=19, pattern 0 -> beats 14..18 of the line = 000000; h_res=5 -> all five beats FFFFFF.
REQ-037 Backpressure: random tready (~50%), pattern 1, h_res=300 -> tdata/tlast/tuser stable while stalled, line values 0..255,0..43, no tvalid drop.
REQ-038 Config change: pattern_sel 3->2 mid-frame -> current frame stays solid; next frame is checker with 32-pixel squares.
REQ-039 Stop/zero: enable dropped at line 1 of 4 -> frame completes, then tvalid=0; h_res=0 with enable=1 -> stays IDLE, frame_cnt unchanged.
REQ-040 Reset: aresetn pulsed mid-line -> all outputs 0 asynchronously; after release the first beat has tuser=1 and x=0.
